// File: rtl/rv32i_gcd_job_ctrl_if.sv
// Host-side request/response channel of the rv32i GCD job sequencer.
// master: host (drives requests, consumes responses); slave: controller.
interface rv32i_gcd_job_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_timeout
  );
endinterface

// File: rtl/rv32i_gcd_job_ctrl.sv
// Job sequencer in front of the rv32i GCD core. Keeps the core in reset while idle, loads an
// operand pair, pulses calc_start, then watches the result until it settles (or times out) and
// hands it back on the response channel. Zero operands are answered directly.
// Optional feature macro: RV32I_GCD_PERF_EN adds the perf_cycles latency output.
module rv32i_gcd_job_ctrl #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32i_gcd_job_ctrl_if.slave  host,
  output logic                 busy,
  output logic                 core_rst_n,
  output logic                 core_calc_start,
  output logic [31:0]          core_gcd_a,
  output logic [31:0]          core_gcd_b,
  input  logic [31:0]          core_gcd_result
`ifdef RV32I_GCD_PERF_EN
  ,
  output logic [CNT_W-1:0]     perf_cycles
`endif
);

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLim  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StCoreRst, StStart, StRun, StResp} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // CORE_RST length, then RUN length
  logic [CNT_W-1:0]  stable_q, stable_d;
  logic [31:0]       prev_q, prev_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       result_q, result_d;
  logic              timeout_q, timeout_d;
  logic              req_ready_c, rsp_valid_c;
  logic              core_rst_n_c, calc_start_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stable_d     = stable_q;
    prev_d       = prev_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    timeout_d    = timeout_q;
    req_ready_c  = 1'b0;
    rsp_valid_c  = 1'b0;
    core_rst_n_c = 1'b0;
    calc_start_c = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_c = 1'b1;
        if (host.req_valid) begin
          a_d = host.req_a;
          b_d = host.req_b;
          if ((host.req_a == 32'd0) || (host.req_b == 32'd0)) begin
            // gcd(0,x) = x: answer without ever releasing the core
            state_d   = StResp;
            result_d  = host.req_a | host.req_b;
            timeout_d = 1'b0;
          end else begin
            state_d = StCoreRst;
            cnt_d   = '0;
          end
        end
      end
      StCoreRst: begin
        if (cnt_q == RstLast) begin
          state_d = StStart;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      StStart: begin
        core_rst_n_c = 1'b1;
        calc_start_c = 1'b1;
        state_d      = StRun;
        cnt_d        = '0;
        stable_d     = '0;
        prev_d       = '0;
      end
      StRun: begin
        core_rst_n_c = 1'b1;
        prev_d       = core_gcd_result;
        cnt_d        = sat_inc(cnt_q);
        if ((core_gcd_result != 32'd0) && (core_gcd_result == prev_q)) begin
          stable_d = sat_inc(stable_q);
        end else begin
          stable_d = '0;
        end
        // Settling is checked first so it wins over a coincident timeout.
        if (stable_d >= StableLim) begin
          state_d   = StResp;
          result_d  = core_gcd_result;
          timeout_d = 1'b0;
        end else if (cnt_d >= TimeoutLim) begin
          state_d   = StResp;
          result_d  = core_gcd_result;
          timeout_d = 1'b1;
        end
      end
      StResp: begin
        rsp_valid_c = 1'b1;
        if (host.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign host.req_ready   = req_ready_c;
  assign host.rsp_valid   = rsp_valid_c;
  assign host.rsp_result  = result_q;
  assign host.rsp_timeout = timeout_q;
  assign busy             = (state_q != StIdle);
  assign core_rst_n       = core_rst_n_c;
  assign core_calc_start  = calc_start_c;
  assign core_gcd_a       = a_q;
  assign core_gcd_b       = b_q;

`ifdef RV32I_GCD_PERF_EN
  logic [CNT_W-1:0] perf_cnt_q, perf_cnt_d;
  logic [CNT_W-1:0] perf_q, perf_d;

  // Latency counter: 1 in the cycle after accept, captured as the rsp_valid rise arrives.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    perf_d     = perf_q;
    if ((state_q == StIdle) && host.req_valid) begin
      perf_cnt_d = CNT_W'(1);
    end else if ((state_q != StIdle) && (state_q != StResp)) begin
      perf_cnt_d = sat_inc(perf_cnt_q);
    end
    if ((state_d == StResp) && (state_q != StResp)) begin
      perf_d = (state_q == StIdle) ? CNT_W'(1) : sat_inc(perf_cnt_q);
    end
  end

  // Latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_q     <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_rv32i_gcd_job_ctrl.sv
// Self-checking bench for rv32i_gcd_job_ctrl: randomized jobs against a stub core whose result
// trace is chosen per job, checked cycle by cycle against a timeline model of the job.
`timescale 1ns/1ps
module tb_rv32i_gcd_job_ctrl;
  localparam int unsigned RstCycles     = 4;
  localparam int unsigned StableCycles  = 8;
  localparam int unsigned TimeoutCycles = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, core_rst_n, core_calc_start;
  logic [31:0] core_gcd_a, core_gcd_b, core_gcd_result;
`ifdef RV32I_GCD_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] trace [0:255];
  logic [7:0]  idx;

  rv32i_gcd_job_ctrl_if host ();

  rv32i_gcd_job_ctrl #(
    .RST_CYCLES     (RstCycles),
    .STABLE_CYCLES  (StableCycles),
    .TIMEOUT_CYCLES (TimeoutCycles),
    .CNT_W          (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host            (host.slave),
    .busy            (busy),
    .core_rst_n      (core_rst_n),
    .core_calc_start (core_calc_start),
    .core_gcd_a      (core_gcd_a),
    .core_gcd_b      (core_gcd_b),
    .core_gcd_result (core_gcd_result)
`ifdef RV32I_GCD_PERF_EN
    ,
    .perf_cycles     (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Stub core: plays trace[1], trace[2], ... in the cycles following its start pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) idx <= 8'd0;
    else if (!core_rst_n) idx <= 8'd0;
    else if (core_calc_start) idx <= 8'd1;
    else if (idx != 8'd0 && idx != 8'd255) idx <= idx + 8'd1;
  end
  assign core_gcd_result = (idx == 8'd0) ? 32'd0 : trace[idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    x = a;
    y = b;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  // First RUN cycle j whose trailing window trace[j-8..j] is one nonzero value; 0 if none in time.
  function automatic int done_cycle();
    for (int j = StableCycles + 1; j <= TimeoutCycles; j++) begin
      bit ok;
      ok = (trace[j] != 32'd0);
      for (int i = 1; i <= StableCycles; i++) if (trace[j-i] != trace[j]) ok = 1'b0;
      if (ok) return j;
    end
    return 0;
  endfunction

  // Plateaus of at most StableCycles equal values, never long enough to look settled.
  task automatic fill_noise(input int from, input int to, input logic [31:0] avoid);
    logic [31:0] v;
    int i;
    v = 32'd0;
    i = from;
    while (i <= to) begin
      int len;
      logic [31:0] nv;
      len = $urandom_range(1, StableCycles);
      do nv = $urandom_range(1, 1000); while (nv == v || nv == avoid);
      v = nv;
      for (int k = 0; k < len && i <= to; k++) begin
        trace[i] = v;
        i++;
      end
    end
  endtask

  task automatic clear_trace();
    for (int i = 0; i < 256; i++) trace[i] = 32'd0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, host.req_ready, 1);
    chk({tag, "_rsp_valid"}, host.rsp_valid, 0);
    chk({tag, "_rsp_result"}, host.rsp_result, 0);
    chk({tag, "_rsp_timeout"}, host.rsp_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_rst_n"}, core_rst_n, 0);
    chk({tag, "_calc_start"}, core_calc_start, 0);
    chk({tag, "_core_a"}, core_gcd_a, 0);
    chk({tag, "_core_b"}, core_gcd_b, 0);
  endtask

  // mode 0: settled from RUN cycle 1; 1: noise then settle; 2: stuck at 0; 3: never settles.
  // Called and returns at a negedge with the DUT idle. abort_at > 0 pulses rst at that cycle.
  task automatic do_job(input logic [31:0] a, input logic [31:0] b, input int mode,
                        input int hold, input int pre_idle, input int abort_at);
    logic [31:0] g, er;
    logic        et, zero;
    int          rs, d, k, s;

    repeat (pre_idle) begin
      @(negedge clk);
      chk("idle_ready", host.req_ready, 1);
      chk("idle_busy", busy, 0);
    end

    clear_trace();
    g = gcd_ref(a, b);
    case (mode)
      0: for (int i = 1; i < 256; i++) trace[i] = g;
      1: begin
        s = $urandom_range(2, 40);
        fill_noise(1, s - 1, g);
        for (int i = s; i < 256; i++) trace[i] = g;
      end
      3: fill_noise(1, 255, 32'd0);
      default: ;
    endcase

    zero = (a == 32'd0) || (b == 32'd0);
    if (zero) begin
      rs = 1;
      er = a | b;
      et = 1'b0;
    end else begin
      d  = done_cycle();
      k  = (d == 0) ? int'(TimeoutCycles) : d;
      et = (d == 0);
      er = trace[k];
      rs = RstCycles + 2 + k;
    end

    host.req_valid = 1'b1;
    host.req_a     = a;
    host.req_b     = b;
    host.rsp_ready = 1'b0;
    chk("accept_ready", host.req_ready, 1);
    chk("accept_busy", busy, 0);

    for (int t = 1; t <= rs + hold + 1; t++) begin
      @(negedge clk);
      if (t == 1) begin
        host.req_valid = 1'b0;
        host.req_a     = $urandom;
        host.req_b     = $urandom;
      end
      if (t == abort_at) begin
        #2 rst = 1'b1;
        #1 chk_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (t < rs) begin
        chk("run_busy", busy, 1);
        chk("run_req_ready", host.req_ready, 0);
        chk("run_rsp_valid", host.rsp_valid, 0);
        chk("run_core_rst_n", core_rst_n, (!zero && t >= int'(RstCycles) + 1) ? 1 : 0);
        chk("run_calc_start", core_calc_start, (!zero && t == int'(RstCycles) + 1) ? 1 : 0);
        chk("run_core_a", core_gcd_a, a);
        chk("run_core_b", core_gcd_b, b);
      end else if (t <= rs + hold) begin
        chk("rsp_valid", host.rsp_valid, 1);
        chk("rsp_result", host.rsp_result, er);
        chk("rsp_timeout", host.rsp_timeout, et);
        chk("rsp_req_ready", host.req_ready, 0);
        chk("rsp_busy", busy, 1);
        chk("rsp_core_rst_n", core_rst_n, 0);
        chk("rsp_calc_start", core_calc_start, 0);
        chk("rsp_core_a", core_gcd_a, a);
`ifdef RV32I_GCD_PERF_EN
        if (t == rs) chk("perf_cycles", perf_cycles, rs);
`endif
        // Offer a new request during RESP; it must not be taken before IDLE.
        host.req_valid = 1'b1;
        host.req_a     = 32'd0;
        host.req_b     = 32'd7;
        host.rsp_ready = (t == rs + hold);
      end else begin
        chk("done_rsp_valid", host.rsp_valid, 0);
        chk("done_req_ready", host.req_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_core_rst_n", core_rst_n, 0);
        host.req_valid = 1'b0;
        host.rsp_ready = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rg;
    int sel, mode;

    rst            = 1'b1;
    host.req_valid = 1'b0;
    host.req_a     = 32'd0;
    host.req_b     = 32'd0;
    host.rsp_ready = 1'b0;
    clear_trace();
    #3 chk_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_values("after_rst");

    // Model pins with hand-computed values.
    chk("pin_gcd_48_18", gcd_ref(48, 18), 6);
    chk("pin_gcd_100_75", gcd_ref(100, 75), 25);
    chk("pin_gcd_21_14", gcd_ref(21, 14), 7);
    chk("pin_gcd_0_35", gcd_ref(0, 35), 35);
    for (int i = 1; i < 256; i++) trace[i] = 32'd9;
    chk("pin_done_flat", done_cycle(), 9);
    for (int i = 9; i < 256; i++) trace[i] = 32'd6;
    chk("pin_done_step", done_cycle(), 17);
    clear_trace();
    chk("pin_done_zero", done_cycle(), 0);

    // Directed jobs.
    do_job(32'd48, 32'd18, 0, 0, 1, 0);
    do_job(32'd0, 32'd35, 0, 0, 1, 0);
    do_job(32'd0, 32'd0, 0, 0, 0, 0);
    do_job(32'd35, 32'd0, 1, 2, 0, 0);
    do_job(32'd12, 32'd8, 2, 0, 1, 0);
    do_job(32'd100, 32'd75, 0, 10, 0, 0);
    do_job(32'd91, 32'd65, 3, 1, 0, 0);
    do_job(32'd30, 32'd45, 1, 0, 0, 0);
    do_job(32'd9, 32'd27, 2, 0, 1, 12);
    do_job(32'd21, 32'd14, 0, 0, 0, 0);

    // Randomized jobs.
    for (int n = 0; n < 30; n++) begin
      rg  = $urandom_range(1, 50);
      ra  = rg * $urandom_range(0, 40);
      rb  = rg * $urandom_range(1, 40);
      if ($urandom_range(0, 5) == 0) ra = 32'd0;
      sel  = $urandom_range(0, 9);
      mode = (sel < 5) ? 1 : (sel < 8) ? 0 : (sel == 8) ? 3 : 2;
      do_job(ra, rb, mode, $urandom_range(0, 4), $urandom_range(0, 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
